// File: rtl/axi_lite_timer_if.sv
// AXI-Lite bus bundle for the timer peripheral. Signal names keep the
// slave-side suffixes so the wiring reads the same on both sides of the CDC.
interface axi_lite_timer_if;
  logic        arvalid_i;
  logic        arready_o;
  logic [31:0] araddr_i;
  logic        rvalid_o;
  logic        rready_i;
  logic [31:0] rdata_o;
  logic [1:0]  rresp_o;
  logic        awvalid_i;
  logic        awready_o;
  logic [31:0] awaddr_i;
  logic        wvalid_i;
  logic        wready_o;
  logic [31:0] wdata_i;
  logic        bvalid_o;
  logic        bready_i;
  logic [1:0]  bresp_o;

  modport slave (
    input  arvalid_i, araddr_i, rready_i,
    input  awvalid_i, awaddr_i, wvalid_i, wdata_i, bready_i,
    output arready_o, rvalid_o, rdata_o, rresp_o,
    output awready_o, wready_o, bvalid_o, bresp_o
  );

  modport master (
    output arvalid_i, araddr_i, rready_i,
    output awvalid_i, awaddr_i, wvalid_i, wdata_i, bready_i,
    input  arready_o, rvalid_o, rdata_o, rresp_o,
    input  awready_o, wready_o, bvalid_o, bresp_o
  );
endinterface

// File: rtl/axi_lite_timer.sv
// AXI-Lite timer peripheral: prescaled up-counter, compare match with optional
// auto-reload, sticky match flag and level interrupt.
// Handshakes suit a FIFO-backed master: readies are one-cycle pop pulses and
// every response is followed by a one-cycle valid-low gap.
// Optional PWM output and DUTY register (0x14) when AXI_LITE_TIMER_PWM_EN is
// defined; otherwise 0x14 is unmapped.
module axi_lite_timer #(
  parameter int CNT_WIDTH   = 32,
  parameter int PRESC_WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  axi_lite_timer_if.slave  bus,
  output logic             irq_o
`ifdef AXI_LITE_TIMER_PWM_EN
  ,
  output logic             pwm_o
`endif
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] IDX_CTRL    = 3'd0;
  localparam logic [2:0] IDX_PRESC   = 3'd1;
  localparam logic [2:0] IDX_COUNT   = 3'd2;
  localparam logic [2:0] IDX_COMPARE = 3'd3;
  localparam logic [2:0] IDX_STATUS  = 3'd4;
  localparam logic [2:0] IDX_DUTY    = 3'd5;

  typedef enum logic [1:0] {R_IDLE, R_DATA, R_GAP} rstate_t;
  typedef enum logic [1:0] {W_COLLECT, W_RESP, W_GAP} wstate_t;

  // Register file
  logic [2:0]             r_ctrl;       // [0] enable, [1] irq_en, [2] auto_reload
  logic [PRESC_WIDTH-1:0] r_presc;
  logic [PRESC_WIDTH-1:0] r_presc_cnt;
  logic [CNT_WIDTH-1:0]   r_count;
  logic [CNT_WIDTH-1:0]   r_compare;
  logic                   r_match;
  logic                   r_irq;
`ifdef AXI_LITE_TIMER_PWM_EN
  logic [CNT_WIDTH-1:0]   r_duty;
  logic                   r_pwm;
`endif

  // Read channel state
  rstate_t     r_rstate;
  rstate_t     w_rstate_nxt;
  logic        w_ar_accept;
  logic        w_rvalid;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic [31:0] w_rd_data;
  logic [1:0]  w_rd_resp;

  // Write channel state
  wstate_t     r_wstate;
  wstate_t     w_wstate_nxt;
  logic        r_aw_got;
  logic        r_w_got;
  logic [2:0]  r_awidx;
  logic [31:0] r_wdata;
  logic [1:0]  r_bresp;
  logic        w_aw_accept;
  logic        w_w_accept;
  logic        w_wr_fire;
  logic        w_bvalid;
  logic [2:0]  w_wr_idx;
  logic [31:0] w_wr_data;
  logic [1:0]  w_wr_resp;

  // Register write strobes
  logic w_we_ctrl;
  logic w_we_presc;
  logic w_we_count;
  logic w_we_compare;
  logic w_we_status;
`ifdef AXI_LITE_TIMER_PWM_EN
  logic w_we_duty;
`endif

  // Timer datapath
  logic w_tick;
  logic w_hit;

  // Address bits outside [4:2] are intentionally ignored.
  logic w_unused;
  assign w_unused = ^{bus.araddr_i[31:5], bus.araddr_i[1:0],
                      bus.awaddr_i[31:5], bus.awaddr_i[1:0]};

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------

  // Read FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_rstate <= R_IDLE;
    else       r_rstate <= w_rstate_nxt;
  end

  // Read FSM next state and handshake outputs; accept is suppressed in reset.
  always_comb begin
    w_rstate_nxt = r_rstate;
    w_ar_accept  = 1'b0;
    w_rvalid     = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (bus.arvalid_i && !rst_i) begin
          w_ar_accept  = 1'b1;
          w_rstate_nxt = R_DATA;
        end
      end
      R_DATA: begin
        w_rvalid = 1'b1;
        if (bus.rready_i) w_rstate_nxt = R_GAP;
      end
      R_GAP:   w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  // Read mux over the register values as they stand in the accept cycle.
  always_comb begin
    w_rd_data = '0;
    w_rd_resp = RESP_OKAY;
    case (bus.araddr_i[4:2])
      IDX_CTRL:    w_rd_data = 32'(r_ctrl);
      IDX_PRESC:   w_rd_data = 32'(r_presc);
      IDX_COUNT:   w_rd_data = 32'(r_count);
      IDX_COMPARE: w_rd_data = 32'(r_compare);
      IDX_STATUS:  w_rd_data = 32'(r_match);
`ifdef AXI_LITE_TIMER_PWM_EN
      IDX_DUTY:    w_rd_data = 32'(r_duty);
`endif
      default:     w_rd_resp = RESP_SLVERR;
    endcase
  end

  // Capture read data/response at accept; held stable through R_DATA.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rdata <= '0;
      r_rresp <= RESP_OKAY;
    end else if (w_ar_accept) begin
      r_rdata <= w_rd_data;
      r_rresp <= w_rd_resp;
    end
  end

  assign bus.arready_o = w_ar_accept;
  assign bus.rvalid_o  = w_rvalid;
  assign bus.rdata_o   = r_rdata;
  assign bus.rresp_o   = r_rresp;

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------

  // Write FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_wstate <= W_COLLECT;
    else       r_wstate <= w_wstate_nxt;
  end

  // Write FSM: AW and W collected independently; the register update fires in
  // the cycle the second of the two arrives (or both together).
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_aw_accept  = 1'b0;
    w_w_accept   = 1'b0;
    w_wr_fire    = 1'b0;
    w_bvalid     = 1'b0;
    case (r_wstate)
      W_COLLECT: begin
        w_aw_accept = bus.awvalid_i && !r_aw_got && !rst_i;
        w_w_accept  = bus.wvalid_i  && !r_w_got  && !rst_i;
        w_wr_fire   = (r_aw_got || w_aw_accept) && (r_w_got || w_w_accept);
        if (w_wr_fire) w_wstate_nxt = W_RESP;
      end
      W_RESP: begin
        w_bvalid = 1'b1;
        if (bus.bready_i) w_wstate_nxt = W_GAP;
      end
      W_GAP:   w_wstate_nxt = W_COLLECT;
      default: w_wstate_nxt = W_COLLECT;
    endcase
  end

  // Use the freshly presented address/data when that channel lands this cycle.
  assign w_wr_idx  = r_aw_got ? r_awidx : bus.awaddr_i[4:2];
  assign w_wr_data = r_w_got  ? r_wdata : bus.wdata_i;

  // Write decode: per-register strobes and the response code.
  always_comb begin
    w_we_ctrl    = 1'b0;
    w_we_presc   = 1'b0;
    w_we_count   = 1'b0;
    w_we_compare = 1'b0;
    w_we_status  = 1'b0;
`ifdef AXI_LITE_TIMER_PWM_EN
    w_we_duty    = 1'b0;
`endif
    w_wr_resp    = RESP_OKAY;
    case (w_wr_idx)
      IDX_CTRL:    w_we_ctrl    = w_wr_fire;
      IDX_PRESC:   w_we_presc   = w_wr_fire;
      IDX_COUNT:   w_we_count   = w_wr_fire;
      IDX_COMPARE: w_we_compare = w_wr_fire;
      IDX_STATUS:  w_we_status  = w_wr_fire;
`ifdef AXI_LITE_TIMER_PWM_EN
      IDX_DUTY:    w_we_duty    = w_wr_fire;
`endif
      default:     w_wr_resp    = RESP_SLVERR;
    endcase
  end

  // Channel capture flags, held address/data and the write response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
      r_awidx  <= '0;
      r_wdata  <= '0;
      r_bresp  <= RESP_OKAY;
    end else if (w_wr_fire) begin
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
      r_bresp  <= w_wr_resp;
    end else begin
      if (w_aw_accept) begin
        r_aw_got <= 1'b1;
        r_awidx  <= bus.awaddr_i[4:2];
      end
      if (w_w_accept) begin
        r_w_got <= 1'b1;
        r_wdata <= bus.wdata_i;
      end
    end
  end

  assign bus.awready_o = w_aw_accept;
  assign bus.wready_o  = w_w_accept;
  assign bus.bvalid_o  = w_bvalid;
  assign bus.bresp_o   = r_bresp;

  // ---------------------------------------------------------------------------
  // Timer core
  // ---------------------------------------------------------------------------

  assign w_tick = r_ctrl[0] && (r_presc_cnt == r_presc);
  assign w_hit  = (r_count == r_compare);

  // Software-only configuration registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ctrl    <= '0;
      r_presc   <= '0;
      r_compare <= '0;
    end else begin
      if (w_we_ctrl)    r_ctrl    <= w_wr_data[2:0];
      if (w_we_presc)   r_presc   <= w_wr_data[PRESC_WIDTH-1:0];
      if (w_we_compare) r_compare <= w_wr_data[CNT_WIDTH-1:0];
    end
  end

  // Prescaler: a PRESCALE write restarts the divide; disabled freezes it.
  always_ff @(posedge clk_i) begin
    if (rst_i)           r_presc_cnt <= '0;
    else if (w_we_presc) r_presc_cnt <= '0;
    else if (r_ctrl[0])  r_presc_cnt <= w_tick ? '0 : r_presc_cnt + PRESC_WIDTH'(1);
  end

  // Counter: software write beats a same-cycle tick; reload only on a hit.
  always_ff @(posedge clk_i) begin
    if (rst_i)           r_count <= '0;
    else if (w_we_count) r_count <= w_wr_data[CNT_WIDTH-1:0];
    else if (w_tick)     r_count <= (w_hit && r_ctrl[2]) ? '0 : r_count + CNT_WIDTH'(1);
  end

  // Sticky match flag (set beats W1C) and the registered interrupt level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_match <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      if (w_tick && w_hit)                  r_match <= 1'b1;
      else if (w_we_status && w_wr_data[0]) r_match <= 1'b0;
      r_irq <= r_match && r_ctrl[1];
    end
  end

  assign irq_o = r_irq;

`ifdef AXI_LITE_TIMER_PWM_EN
  // DUTY register and registered PWM compare against the live count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_duty <= '0;
      r_pwm  <= 1'b0;
    end else begin
      if (w_we_duty) r_duty <= w_wr_data[CNT_WIDTH-1:0];
      r_pwm <= r_ctrl[0] && (r_count < r_duty);
    end
  end

  assign pwm_o = r_pwm;
`endif

endmodule

// File: doc/axi_lite_timer.md
Name: axi_lite_timer

Overview:
- AXI-Lite slave timer peripheral on the slave-clock side of the AXI clock-domain crossing; consumes the AR/AW/W channels it produces and feeds it R/B.
- Provides a prescaled up-counter, compare match with optional auto-reload, a sticky match flag and a level interrupt.
- Handshakes are shaped for a FIFO-backed master: ready is a one-cycle pop pulse, and response valids drop for at least one cycle between beats so that rising-edge detection upstream sees every response.

Parameters:
- CNT_WIDTH, 32, counter/compare width (1..32); register bits above CNT_WIDTH read 0.
- PRESC_WIDTH, 16, prescaler width (1..32).

Ports:
- clk_i  in  1  single clock.
- rst_i  in  1  reset, synchronous, active-high.
- arvalid_i  in  1  read address valid.
- arready_o  out  1  read address accept pulse.
- araddr_i  in  32  read address; only [4:2] decoded.
- rvalid_o  out  1  read data valid.
- rready_i  in  1  read data accept.
- rdata_o  out  32  read data.
- rresp_o  out  2  read response, OKAY=00, SLVERR=10.
- awvalid_i  in  1  write address valid.
- awready_o  out  1  write address accept pulse.
- awaddr_i  in  32  write address; only [4:2] decoded.
- wvalid_i  in  1  write data valid.
- wready_o  out  1  write data accept pulse.
- wdata_i  in  32  write data.
- bvalid_o  out  1  write response valid.
- bready_i  in  1  write response accept.
- bresp_o  out  2  write response.
- irq_o  out  1  interrupt, registered = STATUS.match & CTRL.irq_en.

Behaviour:
- Reset: all outputs 0; all registers 0; both FSMs idle.
- Register map (byte offsets):
  - 0x00 CTRL: [0] enable, [1] irq_en, [2] auto_reload.
  - 0x04 PRESCALE.
  - 0x08 COUNT (R/W).
  - 0x0C COMPARE.
  - 0x10 STATUS: [0] match, write-1-to-clear.
  - All other offsets are unmapped: read data 0 with SLVERR; writes have no effect and return SLVERR.
- Read FSM, R_IDLE -> R_DATA -> R_GAP -> R_IDLE:
  - R_IDLE with arvalid_i: arready_o=1 for exactly one cycle; capture address; go to R_DATA next cycle.
  - R_DATA: rvalid_o=1; rdata/rresp registered, sampled in the accept cycle, held stable until rready_i=1 is sampled.
  - R_GAP: rvalid_o=0 for one cycle.
  - Minimum 3 cycles per read.
- Write FSM, W_COLLECT -> W_RESP -> W_GAP -> W_COLLECT:
  - AW and W are accepted independently, in either order or the same cycle. awready_o (or wready_o) pulses for one cycle when its valid is high and that channel has not yet been captured in the current transaction.
  - The register update occurs in the cycle both are held; W_RESP follows.
  - W_RESP: bvalid_o=1, bresp held until bready_i is sampled high.
  - W_GAP: bvalid_o=0 for one cycle.
  - No further AW/W is accepted during W_RESP or W_GAP.
- Read and write FSMs are independent. A read returns the register value as of the capture cycle.
- Prescaler, when enable=1:
  - presc_cnt increments each cycle.
  - When presc_cnt==PRESCALE: presc_cnt<=0 and tick=1.
  - PRESCALE=0 gives a tick every cycle.
  - enable=0 freezes presc_cnt and COUNT. A PRESCALE write clears presc_cnt.
- On tick:
  - If COUNT==COMPARE: match<=1, and COUNT<=0 if auto_reload else COUNT+1.
  - Otherwise COUNT<=COUNT+1, wrapping from all-ones to 0 with no flag.
- Simultaneous events:
  - A software write to COUNT overrides a tick update in the same cycle.
  - A match set wins over a STATUS W1C clear in the same cycle.
- irq_o follows STATUS/CTRL with one cycle of latency.
- Reset mid-transaction abandons it: valids and readys drop to 0 in the next cycle; no response is generated.

Optional Feature:
- Macro AXI_LITE_TIMER_PWM_EN.
- Defined:
  - Adds port pwm_o (out, 1) and register 0x14 DUTY (CNT_WIDTH bits, R/W, reset 0).
  - pwm_o is registered: 1 when enable=1 and COUNT<DUTY, else 0.
  - DUTY=0 gives pwm_o constant 0.
- Undefined: no pwm_o port; 0x14 is unmapped (SLVERR, reads 0).

Test Plan:
- Reset, then read 0x00..0x10 -> each rdata=0, rresp=00; arready is a 1-cycle pulse; rvalid drops for 1 cycle after each accept.
- Write AW 2 cycles before W, then W before AW, then both together, to COMPARE=5 -> one bresp=00 per write; read-back gives 5; bvalid held 3 cycles when bready is delayed 3 cycles.
- PRESCALE=1, COMPARE=3, CTRL=0b111:
  - COUNT sequence 0,0,1,1,2,2,3,3,0.
  - STATUS.match=1; irq_o=1 one cycle after match.
  - Write STATUS=1 -> irq_o=0.
- auto_reload=0, COUNT written to 0xFFFFFFFE, COMPARE=3, PRESCALE=0 -> COUNT wraps to 0 with no match; match sets when COUNT reaches 3.
- Read 0x18 and write 0x1C -> rresp=10 with rdata=0, bresp=10; no register changes. Assert rst_i while bvalid=1 -> bvalid=0 next cycle and all registers are 0.
- Build with AXI_LITE_TIMER_PWM_EN, DUTY=2, COMPARE=3, auto_reload, PRESCALE=0 -> pwm_o pattern 1,1,0,0 repeating. Build without the macro -> 0x14 returns SLVERR.
